// File: rtl/dcache_miss_queue.sv
// Miss-status holding queue for the direct-mapped data cache: merges duplicate
// block misses, issues BUS_LOAD requests and turns tagged responses into fills.
package dcache_miss_queue_pkg;
    typedef enum logic [1:0] {BUS_NONE = 2'd0, BUS_LOAD = 2'd1, BUS_STORE = 2'd2} BUS_COMMAND;
    typedef enum logic [1:0] {BYTE = 2'd0, HALF = 2'd1, WORD = 2'd2, DOUBLE = 2'd3} MEM_SIZE;
    typedef logic [31:0] DCACHE_DMAP_ADDR;
    typedef logic [63:0] DCACHE_BLOCK;
endpackage

module dcache_miss_queue
    import dcache_miss_queue_pkg::*;
#(
    parameter int NUM_MSHR  = 4,
    parameter int NUM_LINES = 32,
    parameter int TAG_BITS  = 24
) (
    input  logic                          clock,
    input  logic                          reset,
    input  logic                          miss_valid,
    input  DCACHE_DMAP_ADDR               miss_addr,
    output logic                          miss_ready,
    output BUS_COMMAND                    proc2mem_command,
    output logic [31:0]                   proc2mem_addr,
    input  logic                          mem_grant,
    input  logic [3:0]                    mem2proc_response,
    input  logic [63:0]                   mem2proc_data,
    input  logic [3:0]                    mem2proc_tag,
    output logic                          fill_en,
    output DCACHE_DMAP_ADDR               fill_addr,
    output DCACHE_BLOCK                   fill_data,
    output MEM_SIZE                       fill_size,
    output logic [$clog2(NUM_MSHR+1)-1:0] pending
);
    localparam int IDX_W = $clog2(NUM_LINES);
    localparam int OFF_W = 3;
    localparam int EW    = (NUM_MSHR > 1) ? $clog2(NUM_MSHR) : 1;
    localparam int PW    = $clog2(NUM_MSHR + 1);

    typedef enum logic [1:0] {EMPTY, WAIT_ISSUE, WAIT_DATA} entry_state_t;

    entry_state_t        state_reg   [NUM_MSHR];
    logic [TAG_BITS-1:0] tag_reg     [NUM_MSHR];
    logic [IDX_W-1:0]    idx_reg     [NUM_MSHR];
    logic [3:0]          mem_tag_reg [NUM_MSHR];
    logic [PW-1:0]       pending_reg;
    logic                fill_en_reg;
    DCACHE_DMAP_ADDR     fill_addr_reg;
    DCACHE_BLOCK         fill_data_reg;

    logic [TAG_BITS-1:0] miss_tag;
    logic [IDX_W-1:0]    miss_idx;
    logic [OFF_W-1:0]    unused_offset;
    logic [NUM_MSHR-1:0] empty_vec, match_vec, issue_vec, retire_vec;
    logic [EW-1:0]       alloc_sel, issue_sel, retire_sel;
    logic                alloc_fire, issue_fire, retire_fire;

    assign miss_idx      = miss_addr[OFF_W +: IDX_W];
    assign miss_tag      = miss_addr[OFF_W + IDX_W +: TAG_BITS];
    assign unused_offset = miss_addr[OFF_W-1:0];

    function automatic DCACHE_DMAP_ADDR block_addr(input logic [TAG_BITS-1:0] t,
                                                   input logic [IDX_W-1:0] i);
        return DCACHE_DMAP_ADDR'({t, i, {OFF_W{1'b0}}});
    endfunction

    // A retiring entry is still non-empty here, so it keeps absorbing merges this cycle.
    generate
        for (genvar gi = 0; gi < NUM_MSHR; gi++) begin : g_entry
            assign empty_vec[gi]  = (state_reg[gi] == EMPTY);
            assign issue_vec[gi]  = (state_reg[gi] == WAIT_ISSUE);
            assign match_vec[gi]  = !empty_vec[gi] && (tag_reg[gi] == miss_tag)
                                    && (idx_reg[gi] == miss_idx);
            assign retire_vec[gi] = (state_reg[gi] == WAIT_DATA) && (mem2proc_tag != 4'd0)
                                    && (mem_tag_reg[gi] == mem2proc_tag);
        end
    endgenerate

    // Descending scan: the last hit written is the lowest index.
    always_comb begin
        alloc_sel  = '0;
        issue_sel  = '0;
        retire_sel = '0;
        for (int i = NUM_MSHR - 1; i >= 0; i--) begin
            if (empty_vec[i])  alloc_sel  = EW'(i);
            if (issue_vec[i])  issue_sel  = EW'(i);
            if (retire_vec[i]) retire_sel = EW'(i);
        end
    end

    assign miss_ready  = reset && ((|empty_vec) || (|match_vec));
    assign alloc_fire  = miss_valid && miss_ready && !(|match_vec);
    assign issue_fire  = (|issue_vec) && mem_grant && (mem2proc_response != 4'd0);
    assign retire_fire = |retire_vec;

    assign proc2mem_command = (|issue_vec) ? BUS_LOAD : BUS_NONE;
    assign proc2mem_addr    = (|issue_vec) ? block_addr(tag_reg[issue_sel], idx_reg[issue_sel])
                                           : 32'd0;

    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            for (int i = 0; i < NUM_MSHR; i++) begin
                state_reg[i]   <= EMPTY;
                tag_reg[i]     <= '0;
                idx_reg[i]     <= '0;
                mem_tag_reg[i] <= '0;
            end
            pending_reg   <= '0;
            fill_en_reg   <= 1'b0;
            fill_addr_reg <= '0;
            fill_data_reg <= '0;
        end else begin
            for (int i = 0; i < NUM_MSHR; i++) begin
                if (alloc_fire && (alloc_sel == EW'(i))) begin
                    state_reg[i] <= WAIT_ISSUE;
                    tag_reg[i]   <= miss_tag;
                    idx_reg[i]   <= miss_idx;
                end else if (issue_fire && (issue_sel == EW'(i))) begin
                    state_reg[i]   <= WAIT_DATA;
                    mem_tag_reg[i] <= mem2proc_response;
                end else if (retire_vec[i]) begin
                    state_reg[i] <= EMPTY;
                end
            end
            pending_reg <= pending_reg + PW'(alloc_fire) - PW'(retire_fire);
            fill_en_reg <= retire_fire;
            if (retire_fire) begin
                fill_addr_reg <= block_addr(tag_reg[retire_sel], idx_reg[retire_sel]);
                fill_data_reg <= mem2proc_data;
            end
        end
    end

    assign fill_en   = fill_en_reg;
    assign fill_addr = fill_addr_reg;
    assign fill_data = fill_data_reg;
    assign fill_size = DOUBLE;
    assign pending   = pending_reg;
endmodule

// File: tb/tb_dcache_miss_queue.sv
// Scoreboard bench for dcache_miss_queue: stimulus queues expected fills, a
// negedge monitor pops and compares them as fill_en appears.
module tb_dcache_miss_queue;
    import dcache_miss_queue_pkg::*;

    logic        clock = 1'b0;
    logic        reset = 1'b0;
    logic        miss_valid = 1'b0;
    logic [31:0] miss_addr = '0;
    logic        miss_ready;
    BUS_COMMAND  proc2mem_command;
    logic [31:0] proc2mem_addr;
    logic        mem_grant = 1'b0;
    logic [3:0]  mem2proc_response = '0;
    logic [63:0] mem2proc_data = '0;
    logic [3:0]  mem2proc_tag = '0;
    logic        fill_en;
    logic [31:0] fill_addr;
    logic [63:0] fill_data;
    MEM_SIZE     fill_size;
    logic [2:0]  pending;

    always #5 clock = ~clock;

    dcache_miss_queue dut (
        .clock(clock), .reset(reset),
        .miss_valid(miss_valid), .miss_addr(miss_addr), .miss_ready(miss_ready),
        .proc2mem_command(proc2mem_command), .proc2mem_addr(proc2mem_addr),
        .mem_grant(mem_grant), .mem2proc_response(mem2proc_response),
        .mem2proc_data(mem2proc_data), .mem2proc_tag(mem2proc_tag),
        .fill_en(fill_en), .fill_addr(fill_addr), .fill_data(fill_data),
        .fill_size(fill_size), .pending(pending)
    );

    typedef struct {
        logic [31:0] addr;
        logic [63:0] data;
    } fill_t;

    fill_t exp_q[$];
    int total = 0;
    int bad   = 0;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %0h required %0h", name, act, exp);
        end
    endtask

    task automatic step();
        @(posedge clock);
        #1;
    endtask

    task automatic send_miss(input string name, input logic [31:0] a, input logic exp_ready);
        miss_valid = 1'b1;
        miss_addr  = a;
        #1;
        $display("miss %s addr=%08h ready=%0b", name, a, miss_ready);
        chk({name, "_ready"}, 64'(miss_ready), 64'(exp_ready));
        step();
        miss_valid = 1'b0;
    endtask

    task automatic do_grant(input string name, input logic [3:0] resp, input logic [31:0] exp_addr);
        mem_grant         = 1'b1;
        mem2proc_response = resp;
        #1;
        $display("grant %s resp=%0d addr=%08h", name, resp, proc2mem_addr);
        chk({name, "_cmd"}, 64'(proc2mem_command), 64'(BUS_LOAD));
        chk({name, "_addr"}, 64'(proc2mem_addr), 64'(exp_addr));
        step();
        mem_grant         = 1'b0;
        mem2proc_response = '0;
    endtask

    task automatic do_resp(input logic [3:0] t, input logic [31:0] a, input logic [63:0] d,
                           input bit expect_fill);
        mem2proc_tag  = t;
        mem2proc_data = d;
        if (expect_fill) exp_q.push_back('{addr: a, data: d});
        $display("resp tag=%0d data=%016h expect_fill=%0b", t, d, expect_fill);
        step();
        mem2proc_tag  = '0;
        mem2proc_data = '0;
    endtask

    // Monitor: every fill must match the oldest expected one.
    initial begin
        forever begin
            @(negedge clock);
            if (fill_en) begin
                if (exp_q.size() == 0) begin
                    total++;
                    bad++;
                    $display("FAIL unexpected_fill: got addr=%08h data=%016h, required no fill",
                             fill_addr, fill_data);
                end else begin
                    fill_t e;
                    e = exp_q.pop_front();
                    $display("fill addr=%08h data=%016h", fill_addr, fill_data);
                    chk("fill_addr", 64'(fill_addr), 64'(e.addr));
                    chk("fill_data", fill_data, e.data);
                    chk("fill_size", 64'(fill_size), 64'(DOUBLE));
                end
            end
        end
    end

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout, required completion");
        $fatal(1, "watchdog");
    end

    initial begin
        // Reset values
        #2;
        chk("rst_ready", 64'(miss_ready), 64'd0);
        chk("rst_cmd", 64'(proc2mem_command), 64'(BUS_NONE));
        chk("rst_pending", 64'(pending), 64'd0);
        chk("rst_fill_en", 64'(fill_en), 64'd0);
        chk("rst_fill_size", 64'(fill_size), 64'(DOUBLE));
        step();
        reset = 1'b1;
        step();

        // 1: single miss
        chk("t1_pending0", 64'(pending), 64'd0);
        send_miss("t1", 32'h0000_122D, 1'b1);
        chk("t1_pending1", 64'(pending), 64'd1);
        do_grant("t1", 4'd3, 32'h0000_1228);
        chk("t1_cmd_idle", 64'(proc2mem_command), 64'(BUS_NONE));
        step(); step(); step();
        do_resp(4'd3, 32'h0000_1228, 64'hDEADBEEF_CAFEF00D, 1'b1);
        chk("t1_pending_end", 64'(pending), 64'd0);
        step();

        // 2: merge
        send_miss("t2a", 32'h0000_344B, 1'b1);
        do_grant("t2", 4'd5, 32'h0000_3448);
        send_miss("t2b", 32'h0000_344B, 1'b1);
        chk("t2_pending_b", 64'(pending), 64'd1);
        chk("t2_cmd_b", 64'(proc2mem_command), 64'(BUS_NONE));
        send_miss("t2c", 32'h0000_3448, 1'b1);
        chk("t2_pending_c", 64'(pending), 64'd1);
        chk("t2_cmd_c", 64'(proc2mem_command), 64'(BUS_NONE));
        do_resp(4'd5, 32'h0000_3448, 64'h0123_4567_89AB_CDEF, 1'b1);
        chk("t2_pending_end", 64'(pending), 64'd0);

        // 3: full, then retire tag 2 frees a slot next cycle
        send_miss("t3_0", 32'h0001_0008, 1'b1);
        send_miss("t3_1", 32'h0001_0110, 1'b1);
        send_miss("t3_2", 32'h0001_0218, 1'b1);
        send_miss("t3_3", 32'h0001_0320, 1'b1);
        chk("t3_pending4", 64'(pending), 64'd4);
        do_grant("t3_g1", 4'd1, 32'h0001_0008);
        do_grant("t3_g2", 4'd2, 32'h0001_0110);
        do_grant("t3_g3", 4'd3, 32'h0001_0218);
        do_grant("t3_g4", 4'd4, 32'h0001_0320);
        chk("t3_cmd_idle", 64'(proc2mem_command), 64'(BUS_NONE));
        miss_valid = 1'b1;
        miss_addr  = 32'h0001_0430;
        #1;
        chk("t3_full_ready", 64'(miss_ready), 64'd0);
        step();
        mem2proc_tag  = 4'd2;
        mem2proc_data = 64'h2222_0000_0000_0002;
        exp_q.push_back('{addr: 32'h0001_0110, data: 64'h2222_0000_0000_0002});
        #1;
        chk("t3_retire_cycle_ready", 64'(miss_ready), 64'd0);
        step();
        mem2proc_tag  = '0;
        mem2proc_data = '0;
        #1;
        chk("t3_freed_ready", 64'(miss_ready), 64'd1);
        chk("t3_pending3", 64'(pending), 64'd3);
        step();
        miss_valid = 1'b0;
        chk("t3_pending_refill", 64'(pending), 64'd4);
        do_grant("t3_g5", 4'd2, 32'h0001_0430);
        do_resp(4'd1, 32'h0001_0008, 64'h1111_0000_0000_0001, 1'b1);
        do_resp(4'd3, 32'h0001_0218, 64'h3333_0000_0000_0003, 1'b1);
        do_resp(4'd4, 32'h0001_0320, 64'h4444_0000_0000_0004, 1'b1);
        do_resp(4'd2, 32'h0001_0430, 64'h5555_0000_0000_0005, 1'b1);
        chk("t3_pending_end", 64'(pending), 64'd0);

        // 4: reject twice, then accept with tag 7
        send_miss("t4", 32'h ABCD_EFF8, 1'b1);
        do_grant("t4_rej1", 4'd0, 32'hABCD_EFF8);
        do_grant("t4_rej2", 4'd0, 32'hABCD_EFF8);
        do_grant("t4_acc", 4'd7, 32'hABCD_EFF8);
        chk("t4_cmd_idle", 64'(proc2mem_command), 64'(BUS_NONE));
        do_resp(4'd6, 32'h0, 64'h6666_6666_6666_6666, 1'b0);
        chk("t4_pending_held", 64'(pending), 64'd1);
        do_resp(4'd7, 32'hABCD_EFF8, 64'h7777_0000_0000_0007, 1'b1);
        chk("t4_pending_end", 64'(pending), 64'd0);

        // 5: out-of-order return, same index different tags, stray tag
        send_miss("t5_1", 32'h0000_5500, 1'b1);
        send_miss("t5_2", 32'h0000_6600, 1'b1);
        do_grant("t5_g1", 4'd1, 32'h0000_5500);
        do_grant("t5_g2", 4'd2, 32'h0000_6600);
        do_resp(4'd9, 32'h0, 64'h9999_9999_9999_9999, 1'b0);
        chk("t5_pending_stray", 64'(pending), 64'd2);
        do_resp(4'd2, 32'h0000_6600, 64'hAAAA_0000_0000_0002, 1'b1);
        do_resp(4'd1, 32'h0000_5500, 64'hBBBB_0000_0000_0001, 1'b1);
        chk("t5_pending_end", 64'(pending), 64'd0);

        // 6: async reset mid-operation, stale response afterwards
        send_miss("t6_0", 32'h0002_0050, 1'b1);
        send_miss("t6_1", 32'h0002_0158, 1'b1);
        send_miss("t6_2", 32'h0002_0260, 1'b1);
        send_miss("t6_3", 32'h0002_0368, 1'b1);
        do_grant("t6_g4", 4'd4, 32'h0002_0050);
        do_grant("t6_g5", 4'd5, 32'h0002_0158);
        do_resp(4'd4, 32'h0002_0050, 64'hCCCC_0000_0000_0004, 1'b1);
        chk("t6_pending3", 64'(pending), 64'd3);
        #6;
        reset = 1'b0;
        #1;
        chk("t6_rst_pending", 64'(pending), 64'd0);
        chk("t6_rst_cmd", 64'(proc2mem_command), 64'(BUS_NONE));
        chk("t6_rst_ready", 64'(miss_ready), 64'd0);
        chk("t6_rst_fill_en", 64'(fill_en), 64'd0);
        chk("t6_rst_fill_addr", 64'(fill_addr), 64'd0);
        chk("t6_rst_fill_data", fill_data, 64'd0);
        step();
        reset = 1'b1;
        step();
        do_resp(4'd5, 32'h0, 64'hDDDD_0000_0000_0005, 1'b0);
        chk("t6_pending_after", 64'(pending), 64'd0);
        chk("t6_cmd_after", 64'(proc2mem_command), 64'(BUS_NONE));
        step();
        step();
        chk("fills_drained", 64'(exp_q.size()), 64'd0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
